bridge_bus2ram: RTL and testbench
=================================

// Module: bridge_bus2ram
// PURPOSE
//  Bus slave that terminates OCP-style Bus transactions on a single-port synchronous RAM.
//  Sits downstream of the RAM-to-bus master bridges (instruction/data fetch) as the memory target.
//  Delivers read data one cycle after command accept, so a zero-wait master sees no stall.
//  Buffers read responses when the master withholds MRespAccept.
// PARAMETERS
//  ADDR_WIDTH   32    Bus byte-address width
//  DATA_WIDTH   32    Bus/RAM data width; power of 2, >= 8
//  RAM_WORDS    4096  RAM depth in words; word addresses >= RAM_WORDS are out of range
//  RESP_DEPTH   2     Response buffer entries (>= 1); also the max number of outstanding reads
// PORTS
//  clk          in   1             clock; all logic on posedge
//  reset        in   1             asynchronous, active-high
//  MReset_n     in   1             bus soft reset, active-low, sampled synchronously
//  MCmd         in   3             Bus::IDLE / Bus::WR / Bus::RD
//  MAddr        in   ADDR_WIDTH    byte address
//  MData        in   DATA_WIDTH    write data, same cycle as WR
//  MDataValid   in   1             write data valid
//  MByteEn      in   DATA_WIDTH/8  byte enables
//  MRespAccept  in   1             master takes the current response
//  SCmdAccept   out  1             command accepted this cycle
//  SResp        out  2             Bus::NULL / Bus::DVA / Bus::ERR
//  SData        out  DATA_WIDTH    read data, valid when SResp != NULL
//  ram_en       out  1             RAM access strobe
//  ram_we       out  1             RAM write enable
//  ram_addr     out  $clog2(RAM_WORDS)  word address
//  ram_be       out  DATA_WIDTH/8  RAM byte write enables
//  ram_wdata    out  DATA_WIDTH    RAM write data
//  ram_rdata    in   DATA_WIDTH    RAM read data, valid 1 cycle after ram_en && !ram_we
// BEHAVIOUR
//  Reset (reset=1, or MReset_n=0 at posedge): buffer emptied, in-flight flag cleared.
//   While either is asserted: SCmdAccept=0, SResp=NULL, SData=0, ram_en=0, ram_we=0.
//  Word address: waddr = MAddr >> log2(DATA_WIDTH/8). In range iff waddr < RAM_WORDS.
//  outstanding = inflight + buf_count. Always <= RESP_DEPTH.
//  Accept rule:
//   RD is accepted iff outstanding < RESP_DEPTH, or a buffer pop happens in the same cycle.
//   WR is accepted iff MDataValid=1, independent of credit.
//   SCmdAccept is combinational from these rules.
//  Accepted RD, in range: ram_en=1, ram_we=0, in the same cycle; inflight<=1 with tag OK.
//  Accepted RD, out of range: ram_en=0; inflight<=1 with tag ERR.
//  Accepted WR, in range: ram_en=1, ram_we=1, ram_be=MByteEn, ram_wdata=MData, same cycle.
//   Posted: no response is generated.
//  Accepted WR, out of range: silently dropped; ram_en=0.
//  Response path, cycle after a read accept (inflight=1):
//   Buffer empty: bypass. SResp=DVA, SData=ram_rdata (ERR: SResp=ERR, SData=0).
//    MRespAccept=1: consumed, nothing stored. MRespAccept=0: pushed into the buffer.
//   Buffer non-empty: the new response is pushed; the head is presented.
//  Buffer head: while buf_count>0, SResp/SData show the head entry; it pops on MRespAccept=1.
//  Ordering: responses are strictly in request order.
//  Simultaneous events:
//   Push and pop in the same cycle keep buf_count unchanged.
//   A RD accepted in the same cycle as a pop uses the freed credit.
//  Full: outstanding=RESP_DEPTH -> RD stalls (SCmdAccept=0); WR still proceeds.
//  Minimum read latency: DVA in cycle N+1 for an accept in cycle N.
//  Reset mid-operation: in-flight and buffered responses are discarded, never presented.
// STRUCTURE
//  Bus package (existing) holds the Cmd and Resp enums; no new package types.
//  Local typedef resp_entry_t {resp, data}.
//  Sub-module bus_resp_fifo: parameterised sync FIFO.
//   Ports: push, pop, din, dout, count, empty.
//   flush input driven by !MReset_n.
//   Count width: $clog2(RESP_DEPTH+1).
//  Top level holds accept logic, inflight/tag register and bypass mux.
// TESTING
//  1 Single RD at word 5 (RAM[5]=0xCAFE0005), MRespAccept=1.
//    -> SCmdAccept in cycle N; SResp=DVA, SData=0xCAFE0005 in N+1; SResp=NULL in N+2.
//  2 Back-to-back RDs to 0,1,2,3 with MRespAccept=1.
//    -> accept every cycle; DVA with data RAM[0..3] in N+1..N+4.
//  3 MRespAccept=0, four RDs issued (RESP_DEPTH=2).
//    -> accepts 2 then SCmdAccept=0; raising MRespAccept drains in order; third RD accepted in the pop cycle.
//  4 WR 0x11223344 to word 7 with MByteEn=4'b0101, then RD word 7 (pre 0xAABBCCDD).
//    -> DVA data 0xAA22CC44; no response for the WR.
//  5 RD at waddr=RAM_WORDS -> SResp=ERR, SData=0, ram_en=0.
//    WR there -> no RAM write.
//  6 MReset_n=0 (and separately reset=1) while 2 responses are buffered.
//    -> SResp=NULL next cycle; after release, a fresh RD returns DVA with correct data.

Source files
------------

// File: rtl/bridge_bus2ram_pkg.sv
// Bus protocol encodings shared by the bus masters and the RAM target.
//   cmd_e  : MCmd  encoding (IDLE / WR / RD)
//   resp_e : SResp encoding (NULL / DVA / ERR)
package bridge_bus2ram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2
  } cmd_e;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    DVA  = 2'd1,
    ERR  = 2'd3
  } resp_e;

endpackage

// File: rtl/bridge_bus2ram_resp.sv
// bus_resp_fifo: small synchronous FIFO holding read responses the master
// has not yet taken.
//   clk, reset : clock, async active-high reset
//   flush      : synchronous clear (bus soft reset)
//   push, din  : enqueue an entry
//   pop        : dequeue the head (ignored when empty)
//   dout       : head entry, meaningful while !empty
//   count      : number of stored entries
//   empty      : no entries stored
module bus_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bridge_bus2ram.sv
// bridge_bus2ram: bus slave terminating bus transactions on a single-port
// synchronous RAM. Reads return one cycle after accept; responses the master
// does not take are parked in a small FIFO, which also bounds outstanding reads.
//   clk, reset           : clock, async active-high reset
//   MReset_n             : bus soft reset, active-low, synchronous
//   MCmd/MAddr/MData/
//   MDataValid/MByteEn   : master command, byte address, write data/enables
//   MRespAccept          : master takes the current response
//   SCmdAccept           : command accepted this cycle (combinational)
//   SResp/SData          : response and read data (SData=0 when no data)
//   ram_en/ram_we/ram_addr/ram_be/ram_wdata : RAM port strobes
//   ram_rdata            : RAM read data, one cycle after a read strobe
module bridge_bus2ram
  import bridge_bus2ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WORDS  = 4096,
  parameter int RESP_DEPTH = 2,
  localparam int BE_W      = DATA_WIDTH / 8,
  localparam int RAW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MReset_n,
  input  logic [2:0]            MCmd,
  input  logic [ADDR_WIDTH-1:0] MAddr,
  input  logic [DATA_WIDTH-1:0] MData,
  input  logic                  MDataValid,
  input  logic [BE_W-1:0]       MByteEn,
  input  logic                  MRespAccept,
  output logic                  SCmdAccept,
  output logic [1:0]            SResp,
  output logic [DATA_WIDTH-1:0] SData,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAW-1:0]        ram_addr,
  output logic [BE_W-1:0]       ram_be,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int OFS = $clog2(BE_W);
  localparam int CW  = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    resp_e                 resp;
    logic [DATA_WIDTH-1:0] data;
  } resp_entry_t;

  localparam int EW = $bits(resp_entry_t);

  logic          bus_on;
  logic          in_range;
  logic          is_rd, is_wr;
  logic          rd_acc, wr_acc;
  logic          inflight, tag_err;
  logic [CW:0]   outstanding;
  logic          buf_push, buf_pop, buf_empty;
  logic [CW-1:0] buf_count;
  logic [EW-1:0] buf_dout;
  resp_entry_t   head, fresh, pres;

  // Either reset silences every output, including the combinational ones.
  assign bus_on = MReset_n && !reset;

  // Range test on the byte address is the same as waddr < RAM_WORDS,
  // and keeps every address bit in play.
  assign in_range = ({1'b0, MAddr} < (ADDR_WIDTH + 1)'(64'(RAM_WORDS) * BE_W));
  assign ram_addr = RAW'(MAddr >> OFS);

  assign is_rd = bus_on && (MCmd == RD);
  assign is_wr = bus_on && (MCmd == WR);

  assign outstanding = {1'b0, buf_count} + (CW + 1)'(inflight);

  // A pop in this cycle frees a credit for a read arriving in the same cycle.
  assign buf_pop = bus_on && !buf_empty && MRespAccept;
  assign rd_acc  = is_rd && ((outstanding < (CW + 1)'(RESP_DEPTH)) || buf_pop);
  // Writes are posted, so they never consume response credit.
  assign wr_acc  = is_wr && MDataValid;

  assign SCmdAccept = rd_acc || wr_acc;
  assign ram_en     = (rd_acc || wr_acc) && in_range;
  assign ram_we     = wr_acc && in_range;
  assign ram_be     = MByteEn;
  assign ram_wdata  = MData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      tag_err  <= 1'b0;
    end else if (!MReset_n) begin
      inflight <= 1'b0;
      tag_err  <= 1'b0;
    end else begin
      inflight <= rd_acc;
      tag_err  <= rd_acc && !in_range;
    end
  end

  // Response produced this cycle by the read accepted last cycle.
  always_comb begin
    fresh.resp = tag_err ? ERR : DVA;
    fresh.data = tag_err ? '0 : ram_rdata;
  end

  // The fresh response bypasses the FIFO only if nothing is queued ahead of
  // it and the master takes it right away; otherwise it joins the queue.
  assign buf_push = bus_on && inflight && (!buf_empty || !MRespAccept);
  assign head     = resp_entry_t'(buf_dout);

  always_comb begin
    pres.resp = NULL;
    pres.data = '0;
    if (bus_on) begin
      if (!buf_empty)    pres = head;
      else if (inflight) pres = fresh;
    end
  end

  assign SResp = pres.resp;
  assign SData = pres.data;

  bus_resp_fifo #(
    .W     (EW),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (!MReset_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (fresh),
    .dout  (buf_dout),
    .count (buf_count),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_bridge_bus2ram.sv
module tb_bridge_bus2ram;
  import bridge_bus2ram_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RW  = 64;
  localparam int DEP = 2;
  localparam int RAW = 6;

  logic          clk, reset, MReset_n;
  logic [2:0]    MCmd;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MData;
  logic          MDataValid;
  logic [3:0]    MByteEn;
  logic          MRespAccept;
  logic          SCmdAccept;
  logic [1:0]    SResp;
  logic [DW-1:0] SData;
  logic          ram_en, ram_we;
  logic [RAW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  bridge_bus2ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_WORDS(RW), .RESP_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .MReset_n(MReset_n),
    .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MDataValid(MDataValid),
    .MByteEn(MByteEn), .MRespAccept(MRespAccept),
    .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM attached to the DUT's RAM port.
  logic [DW-1:0] tbram [RW];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) tbram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= tbram[ram_addr];
      end
    end
  end

  // Reference model: shadow memory plus an ordered queue of responses owed.
  logic [DW-1:0] shadow [RW];
  logic [1:0]    q_resp [$];
  logic [DW-1:0] q_data [$];
  int tests = 0;
  int fails = 0;
  logic          obs_acc;
  logic [1:0]    obs_resp;
  logic [DW-1:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic dv, input logic [3:0] be, input logic ra);
    logic bus_on, inr, head_vis, pop, e_acc, e_en, e_we;
    logic [31:0] waddr;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    MCmd = cmd; MAddr = addr; MData = wd; MDataValid = dv; MByteEn = be; MRespAccept = ra;
    #4;
    obs_acc = SCmdAccept; obs_resp = SResp; obs_data = SData;
    bus_on   = !reset && MReset_n;
    waddr    = addr >> 2;
    inr      = waddr < RW;
    head_vis = bus_on && (q_resp.size() > 0);
    e_resp   = head_vis ? q_resp[0] : NULL;
    e_data   = head_vis ? q_data[0] : '0;
    pop      = head_vis && ra;
    e_acc    = bus_on && (((cmd == RD) && ((q_resp.size() < DEP) || pop)) ||
                          ((cmd == WR) && dv));
    e_en     = e_acc && inr;
    e_we     = e_en && (cmd == WR);
    chk("accept", obs_acc, e_acc);
    chk("sresp", obs_resp, e_resp);
    chk("sdata", obs_data, e_data);
    chk("ram_en", ram_en, e_en);
    chk("ram_we", ram_we, e_we);
    if (e_en) chk("ram_addr", ram_addr, waddr);
    if (e_we) begin
      chk("ram_be", ram_be, be);
      chk("ram_wdata", ram_wdata, wd);
    end
    if (!bus_on) begin
      q_resp.delete();
      q_data.delete();
    end else begin
      if (pop) begin
        void'(q_resp.pop_front());
        void'(q_data.pop_front());
      end
      if (e_acc && cmd == RD) begin
        q_resp.push_back(inr ? DVA : ERR);
        q_data.push_back(inr ? shadow[waddr] : '0);
      end
      if (e_we)
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[waddr][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ra);
    step(IDLE, '0, '0, 1'b0, 4'h0, ra);
  endtask

  initial begin
    for (int i = 0; i < RW; i++) begin
      tbram[i]  = $urandom;
      shadow[i] = tbram[i];
    end
    tbram[5] = 32'hCAFE0005; shadow[5] = 32'hCAFE0005;
    tbram[7] = 32'hAABBCCDD; shadow[7] = 32'hAABBCCDD;
    reset = 1'b1; MReset_n = 1'b1;
    MCmd = IDLE; MAddr = '0; MData = '0; MDataValid = 1'b0; MByteEn = '0; MRespAccept = 1'b0;
    @(posedge clk); #1;
    // Reset state: read request must be ignored
    step(RD, 32'd20, '0, 1'b0, 4'h0, 1'b1);
    chk("rst_acc", obs_acc, 1'b0);
    idle(1'b1);
    reset = 1'b0;
    idle(1'b1);

    // 1: single read, zero-wait
    step(RD, 32'd20, '0, 1'b0, 4'h0, 1'b1);
    chk("t1_acc", obs_acc, 1'b1);
    idle(1'b1);
    chk("t1_resp", obs_resp, DVA);
    chk("t1_data", obs_data, 32'hCAFE0005);
    idle(1'b1);
    chk("t1_null", obs_resp, NULL);

    // 2: back-to-back reads
    for (int i = 0; i < 4; i++) begin
      step(RD, 32'(4 * i), '0, 1'b0, 4'h0, 1'b1);
      chk("t2_acc", obs_acc, 1'b1);
    end
    idle(1'b1);
    chk("t2_last", obs_data, shadow[3]);

    // 3: backpressure, credit reuse on pop cycle
    step(RD, 32'd0, '0, 1'b0, 4'h0, 1'b0);  chk("t3_acc0", obs_acc, 1'b1);
    step(RD, 32'd4, '0, 1'b0, 4'h0, 1'b0);  chk("t3_acc1", obs_acc, 1'b1);
    step(RD, 32'd8, '0, 1'b0, 4'h0, 1'b0);  chk("t3_stall", obs_acc, 1'b0);
    step(RD, 32'd8, '0, 1'b0, 4'h0, 1'b0);  chk("t3_stall2", obs_acc, 1'b0);
    step(RD, 32'd8, '0, 1'b0, 4'h0, 1'b1);
    chk("t3_popacc", obs_acc, 1'b1);
    chk("t3_d0", obs_data, shadow[0]);
    idle(1'b1); chk("t3_d1", obs_data, shadow[1]);
    idle(1'b1); chk("t3_d2", obs_data, shadow[2]);
    idle(1'b1); chk("t3_null", obs_resp, NULL);

    // 4: partial write then read back
    step(WR, 32'd28, 32'h11223344, 1'b1, 4'b0101, 1'b1);
    chk("t4_wacc", obs_acc, 1'b1);
    step(RD, 32'd28, '0, 1'b0, 4'h0, 1'b1);
    chk("t4_noresp", obs_resp, NULL);
    idle(1'b1);
    chk("t4_data", obs_data, 32'hAA22CC44);

    // 5: out-of-range read and write
    step(RD, 32'(RW * 4), '0, 1'b0, 4'h0, 1'b1);
    chk("t5_en", ram_en, 1'b0);
    idle(1'b1);
    chk("t5_err", obs_resp, ERR);
    chk("t5_data", obs_data, 32'h0);
    step(WR, 32'(RW * 4 + 4), 32'hDEADBEEF, 1'b1, 4'hF, 1'b1);

    // 6: soft reset, then hard reset, with two responses parked
    for (int k = 0; k < 2; k++) begin
      step(RD, 32'd4, '0, 1'b0, 4'h0, 1'b0);
      step(RD, 32'd8, '0, 1'b0, 4'h0, 1'b0);
      idle(1'b0);
      if (k == 0) MReset_n = 1'b0; else reset = 1'b1;
      idle(1'b1);
      MReset_n = 1'b1; reset = 1'b0;
      idle(1'b1);
      chk("t6_null", obs_resp, NULL);
      step(RD, 32'd20, '0, 1'b0, 4'h0, 1'b1);
      idle(1'b1);
      chk("t6_resp", obs_resp, DVA);
      chk("t6_data", obs_data, 32'hCAFE0005);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] c;
      r = $urandom_range(0, 99);
      c = (r < 40) ? RD : (r < 70) ? WR : IDLE;
      MReset_n = ($urandom_range(0, 49) != 0);
      step(c, 32'($urandom_range(0, RW * 4 + 40)), $urandom, ($urandom_range(0, 3) != 0),
           4'($urandom), ($urandom_range(0, 9) < 6));
    end
    MReset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
